// File: rtl/fire_sequencer.sv
// rtl/fire_sequencer.sv - trigger/reload sequencer producing rate-limited fire pulses, bursts and timed reload
module fire_sequencer #(
  parameter int N             = 9,
  parameter int COOLDOWN      = 4,
  parameter int BURST_LEN     = 3,
  parameter int RELOAD_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trigger,
  input  logic         attack_mode,
  input  logic         burst_en,
  input  logic [N-1:0] ammo,
  input  logic         reload_req,
  input  logic [N-1:0] magazine,
  output logic         fire,
  output logic         load,
  output logic [N-1:0] ammo_in,
  output logic         reloading,
  output logic         busy,
  output logic         dry_fire
);

  localparam int MAX_CB = (COOLDOWN > BURST_LEN) ? COOLDOWN : BURST_LEN;
  localparam int MAXP   = (MAX_CB > RELOAD_CYCLES) ? MAX_CB : RELOAD_CYCLES;
  localparam int CW     = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] COOL_INIT   = CW'(COOLDOWN - 1);
  localparam logic [CW-1:0] RELOAD_INIT = CW'(RELOAD_CYCLES - 1);
  localparam logic [CW-1:0] BURST_INIT  = CW'(BURST_LEN);
  localparam logic [CW-1:0] ONE         = CW'(1);

  typedef enum logic [1:0] {IDLE, FIRE, COOL, RELOAD} state_t;

  state_t        state;
  logic [CW-1:0] shots;
  logic [CW-1:0] ccnt;
  logic [CW-1:0] rcnt;
  logic          trig_q;
  logic          reload_pend;

  logic trig_rise;
  logic can_fire;

  assign trig_rise = trigger & ~trig_q;
  assign can_fire  = attack_mode & (ammo != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shots       <= '0;
      ccnt        <= '0;
      rcnt        <= '0;
      trig_q      <= 1'b0;
      reload_pend <= 1'b0;
      fire        <= 1'b0;
      load        <= 1'b0;
      ammo_in     <= '0;
      reloading   <= 1'b0;
      busy        <= 1'b0;
      dry_fire    <= 1'b0;
    end else begin
      trig_q   <= trigger;
      fire     <= 1'b0;
      load     <= 1'b0;
      dry_fire <= 1'b0;
      ammo_in  <= '0;

      case (state)
        IDLE: begin
          if (reload_req) begin
            state       <= RELOAD;
            rcnt        <= RELOAD_INIT;
            reloading   <= 1'b1;
            busy        <= 1'b1;
            reload_pend <= 1'b0;
            // A one-cycle reload issues its load strobe on the entry cycle itself.
            if (RELOAD_INIT == '0) begin
              load    <= 1'b1;
              ammo_in <= magazine;
            end
          end else if (trig_rise && can_fire) begin
            state <= FIRE;
            shots <= burst_en ? BURST_INIT : ONE;
            fire  <= 1'b1;
            busy  <= 1'b1;
          end else if (trig_rise) begin
            dry_fire <= 1'b1;
          end
        end

        FIRE: begin
          state <= COOL;
          ccnt  <= COOL_INIT;
          if (shots != '0) shots <= shots - ONE;
          if (reload_req) reload_pend <= 1'b1;
        end

        COOL: begin
          if (reload_req) reload_pend <= 1'b1;
          if (ccnt != '0) begin
            ccnt <= ccnt - ONE;
          end else if (reload_pend || reload_req) begin
            state       <= RELOAD;
            rcnt        <= RELOAD_INIT;
            reloading   <= 1'b1;
            reload_pend <= 1'b0;
            shots       <= '0;
            if (RELOAD_INIT == '0) begin
              load    <= 1'b1;
              ammo_in <= magazine;
            end
          end else if ((shots != '0) && trigger && can_fire) begin
            state <= FIRE;
            fire  <= 1'b1;
          end else begin
            state <= IDLE;
            shots <= '0;
            busy  <= 1'b0;
          end
        end

        RELOAD: begin
          if (rcnt != '0) begin
            rcnt <= rcnt - ONE;
            // Load is registered, so it is raised on the edge that enters the final count.
            if (rcnt == ONE) begin
              load    <= 1'b1;
              ammo_in <= magazine;
            end
          end else begin
            state     <= IDLE;
            reloading <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          reloading <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
